// File: rtl/pipeline_deliver_elastic.sv
// pipeline_deliver_elastic: elastic valid/ready pipeline register between two
// core stages. It holds up to DEPTH payloads in a circular queue, presents
// all-zero data on bubbles, supports a synchronous flush and a downstream stall.
// Optional feature macro: PIPELINE_DELIVER_BYPASS_EN (zero-latency pass-through
// when the buffer is empty). Reset rst is synchronous, active-low.
module pipeline_deliver_elastic #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_in,
   input  logic             stall_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             buf_valid;
   logic             push;
   logic             pop;

   // in_ready depends only on registered occupancy, so a full buffer cannot
   // accept in the same cycle it pops and no ready path runs downstream-to-upstream.
   assign in_ready  = rst & (count < CNT_W'(DEPTH));
   assign buf_valid = rst & (count != '0);
   assign push      = in_valid & in_ready & ~flush_in;
   assign pop       = out_valid & out_ready & ~stall_in & ~flush_in;

   // Head presentation: stored head, zero on bubble, or same-cycle bypass.
   // A bypassed payload that is also popped is written and read in the same
   // cycle, so both pointers advance and count stays 0 without special casing.
   always_comb begin
      out_valid = buf_valid;
      out_data  = '0;
      if (buf_valid) begin
         out_data = mem[rd_ptr];
      end
`ifdef PIPELINE_DELIVER_BYPASS_EN
      else if (rst && in_valid && !flush_in) begin
         out_valid = 1'b1;
         out_data  = in_data;
      end
`endif
   end

   // Payload storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy update; reset beats flush, flush beats push/pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush_in) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

`ifndef SYNTHESIS
   // Held head must not change until it is taken or flushed.
   a_hold_stable : assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !(out_ready && !stall_in) && !flush_in) |=> $stable(out_data));

   // Occupancy never exceeds capacity.
   a_count_bound : assert property (@(posedge clk) disable iff (!rst)
      count <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_pipeline_deliver_elastic.sv
// Testbench for pipeline_deliver_elastic: table-driven vectors on a DEPTH=2
// instance, plus a scoreboard wrap sequence on a DEPTH=4 instance.
// Expectations follow PIPELINE_DELIVER_BYPASS_EN when it is defined.
module tb_pipeline_deliver_elastic;

`ifdef PIPELINE_DELIVER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       flush_in;
   logic       stall_in;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_ready;

   logic       ir2, ov2, ir4, ov4;
   logic [7:0] od2, od4;
   logic [1:0] cnt2;
   logic [2:0] cnt4;

   int checks = 0;
   int errors = 0;

   pipeline_deliver_elastic #(.WIDTH(8), .DEPTH(2)) u_dut2 (
      .clk(clk), .rst(rst), .flush_in(flush_in), .stall_in(stall_in),
      .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
      .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .count(cnt2)
   );

   pipeline_deliver_elastic #(.WIDTH(8), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .flush_in(flush_in), .stall_in(stall_in),
      .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
      .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .count(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst, flush, stall, iv;
      logic [7:0] id;
      logic       ordy;
      logic       ir, ov;
      logic [7:0] od;
      int         cnt;
      logic       bov;
      logic [7:0] bod;
      int         bcnt;
   } vec_t;

   localparam int NV = 30;
   vec_t tbl[NV];

   function automatic vec_t mk(logic r, logic f, logic s, logic iv, logic [7:0] id,
                               logic ordy, logic ir, logic ov, logic [7:0] od, int cnt,
                               logic bov, logic [7:0] bod, int bcnt);
      vec_t v;
      v.rst = r;  v.flush = f; v.stall = s; v.iv = iv; v.id = id; v.ordy = ordy;
      v.ir = ir;  v.ov = ov;   v.od = od;   v.cnt = cnt;
      v.bov = bov; v.bod = bod; v.bcnt = bcnt;
      return v;
   endfunction

   // Row whose expectations are identical with and without bypass.
   function automatic vec_t mks(logic r, logic f, logic s, logic iv, logic [7:0] id,
                                logic ordy, logic ir, logic ov, logic [7:0] od, int cnt);
      return mk(r, f, s, iv, id, ordy, ir, ov, od, cnt, ov, od, cnt);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   logic [7:0] q[$];
   int         pushed;
   int         popped;
   logic       exp_ov;
   logic [7:0] exp_d;

   initial begin
      // rst iv  id   ordy | ir ov od cnt | bypass ov od cnt
      for (int i = 0; i < 3; i++) tbl[i] = mks(0,0,0,1,8'h77,1, 0,0,8'h00,0);
      tbl[3]  = mks(1,0,0,0,8'h00,1, 1,0,8'h00,0);
      // streaming
      tbl[4]  = mk (1,0,0,1,8'h11,1, 1,0,8'h00,0, 1,8'h11,0);
      tbl[5]  = mk (1,0,0,1,8'h22,1, 1,1,8'h11,1, 1,8'h22,0);
      tbl[6]  = mk (1,0,0,1,8'h33,1, 1,1,8'h22,1, 1,8'h33,0);
      tbl[7]  = mk (1,0,0,0,8'h00,1, 1,1,8'h33,1, 0,8'h00,0);
      // backpressure
      tbl[8]  = mk (1,0,0,1,8'h0A,0, 1,0,8'h00,0, 1,8'h0A,0);
      tbl[9]  = mks(1,0,0,1,8'h0B,0, 1,1,8'h0A,1);
      tbl[10] = mks(1,0,0,1,8'h0C,0, 0,1,8'h0A,2);
      tbl[11] = mks(1,0,0,1,8'h0C,1, 0,1,8'h0A,2);
      tbl[12] = mks(1,0,0,1,8'h0C,1, 1,1,8'h0B,1);
      tbl[13] = mks(1,0,0,0,8'h00,1, 1,1,8'h0C,1);
      // stall
      tbl[14] = mk (1,0,0,1,8'h55,0, 1,0,8'h00,0, 1,8'h55,0);
      for (int i = 15; i < 19; i++) tbl[i] = mks(1,0,1,0,8'h00,1, 1,1,8'h55,1);
      tbl[19] = mks(1,0,0,0,8'h00,1, 1,1,8'h55,1);
      tbl[20] = mks(1,0,0,0,8'h00,1, 1,0,8'h00,0);
      // flush on a full buffer, then flush discarding a push
      tbl[21] = mk (1,0,0,1,8'h61,0, 1,0,8'h00,0, 1,8'h61,0);
      tbl[22] = mks(1,0,0,1,8'h62,0, 1,1,8'h61,1);
      tbl[23] = mks(1,1,0,1,8'h63,1, 0,1,8'h61,2);
      tbl[24] = mks(1,0,0,0,8'h00,1, 1,0,8'h00,0);
      tbl[25] = mks(1,1,0,1,8'h64,0, 1,0,8'h00,0);
      tbl[26] = mks(1,0,0,0,8'h00,0, 1,0,8'h00,0);
      // reset beats a pending entry
      tbl[27] = mk (1,0,0,1,8'h70,0, 1,0,8'h00,0, 1,8'h70,0);
      tbl[28] = mks(0,0,0,0,8'h00,0, 0,0,8'h00,1);
      tbl[29] = mks(1,0,0,0,8'h00,0, 1,0,8'h00,0);

      rst = 1'b0; flush_in = 1'b0; stall_in = 1'b0;
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = tbl[i].rst; flush_in = tbl[i].flush; stall_in = tbl[i].stall;
         in_valid = tbl[i].iv; in_data = tbl[i].id; out_ready = tbl[i].ordy;
         #2;
         chk($sformatf("r%0d_in_ready", i), 32'(ir2), 32'(tbl[i].ir));
         chk($sformatf("r%0d_out_valid", i), 32'(ov2), 32'(BYP ? tbl[i].bov : tbl[i].ov));
         chk($sformatf("r%0d_out_data", i), 32'(od2), 32'(BYP ? tbl[i].bod : tbl[i].od));
         chk($sformatf("r%0d_count", i), 32'(cnt2), BYP ? tbl[i].bcnt : tbl[i].cnt);
      end

      // Wrap sequence on DEPTH=4: 20 items, random out_ready, scoreboard order.
      pushed = 0;
      popped = 0;
      for (int cyc = 0; cyc < 300 && popped < 20; cyc++) begin
         @(negedge clk);
         rst = 1'b1; flush_in = 1'b0; stall_in = 1'b0;
         in_valid  = (pushed < 20);
         in_data   = 8'h80 + 8'(pushed);
         out_ready = 1'($urandom_range(0, 1));
         #2;
         chk("wrap_count", 32'(cnt4), q.size());
         chk("wrap_in_ready", 32'(ir4), 32'(q.size() < 4));
         exp_ov = (q.size() != 0) || (BYP && in_valid);
         chk("wrap_out_valid", 32'(ov4), 32'(exp_ov));
         if (in_valid && ir4) begin
            q.push_back(in_data);
            pushed++;
         end
         if (ov4 && out_ready) begin
            if (q.size() == 0) begin
               chk("wrap_spurious_pop", 32'(od4), 32'hFFFF_FFFF);
               popped++;
            end else begin
               exp_d = q.pop_front();
               chk("wrap_data", 32'(od4), 32'(exp_d));
               popped++;
            end
         end
      end
      chk("wrap_popped", popped, 20);

      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      chk("wrap_empty_valid", 32'(ov4), 32'(0));
      chk("wrap_empty_data", 32'(od4), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
